// File: rtl/nn_stream_sequencer_pkg.sv
// Shared word format, state encoding and sizing helper for nn_stream_sequencer.
// Words are signed fixed point: INTEGER_WIDTH integral bits over FRACTION_WIDTH fraction bits.
package nn_stream_sequencer_pkg;

  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int WORD_WIDTH     = INTEGER_WIDTH + FRACTION_WIDTH;

  typedef struct packed {
    logic signed [INTEGER_WIDTH-1:0] integral;
    logic [FRACTION_WIDTH-1:0]       fraction;
  } word_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Counter/index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_stream_sequencer_if.sv
// Stream and network-side bundle for nn_stream_sequencer; out_class exists only with ARGMAX_EN.
// Handshake: a beat happens on a rising edge where valid && ready; the sender holds data while valid && !ready.
interface nn_stream_sequencer_if
  import nn_stream_sequencer_pkg::*;
#(
  parameter int NUM_INPUTS  = 10,
  parameter int NUM_OUTPUTS = 10
);
  localparam int CW = idx_width(NUM_OUTPUTS);

  word_t                   in_data;
  logic                    in_valid;
  logic                    in_ready;
  word_t [NUM_INPUTS-1:0]  nn_inputs;
  logic                    nn_inputs_ready;
  word_t [NUM_OUTPUTS-1:0] nn_outputs;
  logic                    nn_outputs_ready;
  word_t                   out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
`ifdef ARGMAX_EN
  logic [CW-1:0]           out_class;
`endif
  logic                    busy;
  seq_state_t              state;

`ifdef ARGMAX_EN
  modport master (
    input  in_data, in_valid, nn_outputs, nn_outputs_ready, out_ready,
    output in_ready, nn_inputs, nn_inputs_ready, out_data, out_valid, out_last,
           out_class, busy, state
  );
  modport slave (
    output in_data, in_valid, nn_outputs, nn_outputs_ready, out_ready,
    input  in_ready, nn_inputs, nn_inputs_ready, out_data, out_valid, out_last,
           out_class, busy, state
  );
`else
  modport master (
    input  in_data, in_valid, nn_outputs, nn_outputs_ready, out_ready,
    output in_ready, nn_inputs, nn_inputs_ready, out_data, out_valid, out_last,
           busy, state
  );
  modport slave (
    output in_data, in_valid, nn_outputs, nn_outputs_ready, out_ready,
    input  in_ready, nn_inputs, nn_inputs_ready, out_data, out_valid, out_last,
           busy, state
  );
`endif

endinterface

// File: rtl/nn_stream_sequencer_argmax_tracker.sv
// Running signed max/index over words presented in index order; used only when ARGMAX_EN is defined.
// class_index updates once, when the final index is presented, and holds until the next pass.
module argmax_tracker
  import nn_stream_sequencer_pkg::*;
#(
  parameter int NUM_WORDS = 10,
  parameter int IW        = idx_width(NUM_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  word_t         word,
  input  logic [IW-1:0] index,
  input  logic          strobe,
  input  logic          clear,
  output logic [IW-1:0] class_index
);
  localparam logic [IW-1:0] LAST_INDEX = IW'(NUM_WORDS - 1);

  logic signed [WORD_WIDTH-1:0] run_max;
  logic [IW-1:0]                run_idx;
  logic signed [WORD_WIDTH-1:0] word_s;
  logic                         take;
  logic [IW-1:0]                best_idx;

  // Strictly greater keeps the earliest index on ties.
  assign word_s   = $signed(word);
  assign take     = clear || (word_s > run_max);
  assign best_idx = take ? index : run_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_max     <= '0;
      run_idx     <= '0;
      class_index <= '0;
    end else if (strobe) begin
      if (take) begin
        run_max <= word_s;
        run_idx <= index;
      end
      if (index == LAST_INDEX) class_index <= best_idx;
    end
  end

endmodule

// File: rtl/nn_stream_sequencer.sv
// Streams samples into the network input array, waits for its result, then streams results out.
// Define ARGMAX_EN to add the out_class argmax output.
module nn_stream_sequencer
  import nn_stream_sequencer_pkg::*;
#(
  parameter int NUM_INPUTS  = 10,
  parameter int NUM_OUTPUTS = 10
) (
  input logic            clock,
  input logic            reset,
  nn_stream_sequencer_if.master bus
);
  localparam int IW = idx_width(NUM_INPUTS);
  localparam int OW = idx_width(NUM_OUTPUTS);
  localparam logic [IW-1:0] IN_LAST  = IW'(NUM_INPUTS - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(NUM_OUTPUTS - 1);

  seq_state_t    state;
  logic [IW-1:0] in_count;
  logic [OW-1:0] out_count;
  logic [OW-1:0] next_count;
  word_t         buffer [NUM_OUTPUTS];
  logic          in_beat;
  logic          out_beat;

  assign in_beat    = bus.in_valid && bus.in_ready;
  assign out_beat   = bus.out_valid && bus.out_ready;
  assign next_count = out_count + 1'b1;
  assign bus.state  = state;

  // Capture buffer lets the network change its outputs while we drain.
  always_ff @(posedge clock) begin
    if (state == RUN && bus.nn_outputs_ready) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) buffer[i] <= bus.nn_outputs[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= LOAD;
      in_count            <= '0;
      out_count           <= '0;
      bus.in_ready        <= 1'b1;
      bus.nn_inputs       <= '0;
      bus.nn_inputs_ready <= 1'b0;
      bus.out_valid       <= 1'b0;
      bus.out_data        <= '0;
      bus.out_last        <= 1'b0;
      bus.busy            <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_beat) begin
            bus.nn_inputs[in_count] <= bus.in_data;
            if (in_count == IN_LAST) begin
              in_count            <= '0;
              bus.in_ready        <= 1'b0;
              bus.nn_inputs_ready <= 1'b1;
              bus.busy            <= 1'b1;
              state               <= RUN;
            end else begin
              in_count <= in_count + 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.nn_outputs_ready) begin
            bus.nn_inputs_ready <= 1'b0;
            bus.out_valid       <= 1'b1;
            bus.out_data        <= bus.nn_outputs[0];
            bus.out_last        <= (OUT_LAST == '0);
            out_count           <= '0;
            state               <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_beat) begin
            if (bus.out_last) begin
              out_count     <= '0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.in_ready  <= 1'b1;
              bus.busy      <= 1'b0;
              state         <= LOAD;
            end else begin
              out_count    <= next_count;
              bus.out_data <= buffer[next_count];
              bus.out_last <= (next_count == OUT_LAST);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef ARGMAX_EN
  word_t         trk_word;
  logic [OW-1:0] trk_index;
  logic          trk_strobe;
  logic          trk_clear;

  // Feed the tracker each word as it is loaded into out_data, so the result is final with out_last.
  always_comb begin
    trk_word   = buffer[next_count];
    trk_index  = next_count;
    trk_clear  = 1'b0;
    trk_strobe = (state == DRAIN) && out_beat && !bus.out_last;
    if (state == RUN) begin
      trk_word   = bus.nn_outputs[0];
      trk_index  = '0;
      trk_clear  = 1'b1;
      trk_strobe = bus.nn_outputs_ready;
    end
  end

  argmax_tracker #(.NUM_WORDS(NUM_OUTPUTS)) u_argmax (
    .clock       (clock),
    .reset       (reset),
    .word        (trk_word),
    .index       (trk_index),
    .strobe      (trk_strobe),
    .clear       (trk_clear),
    .class_index (bus.out_class)
  );
`endif

endmodule

// File: tb/tb_nn_stream_sequencer.sv
// Self-checking bench for nn_stream_sequencer: directed literal cases plus randomized traffic.
// Build with ARGMAX_EN defined to also check out_class.
module tb_nn_stream_sequencer;
  import nn_stream_sequencer_pkg::*;

  localparam int NI = 10;
  localparam int NO = 10;
  localparam int W  = WORD_WIDTH;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  nn_stream_sequencer_if #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) bus ();

  nn_stream_sequencer #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] w32(input logic [W-1:0] v);
    return {16'h0000, v};
  endfunction

  // ---------------- behavioural model + scoreboard ----------------
  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_nn_in [NI];
  logic [W-1:0] exp_out_data;
  logic         exp_in_ready, exp_nn_rdy, exp_out_valid, exp_last, exp_busy;
  int           n_loaded, exp_class, pend_class;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < NI; i++) exp_nn_in[i] = '0;
      exp_out_data  = '0;
      exp_in_ready  = 1'b1;
      exp_nn_rdy    = 1'b0;
      exp_out_valid = 1'b0;
      exp_last      = 1'b0;
      exp_busy      = 1'b0;
      n_loaded      = 0;
      exp_class     = 0;
      pend_class    = 0;
    end

    check("in_ready", 32'(bus.in_ready), 32'(exp_in_ready));
    check("nn_inputs_ready", 32'(bus.nn_inputs_ready), 32'(exp_nn_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(exp_out_valid));
    check("out_last", 32'(bus.out_last), 32'(exp_last));
    check("busy", 32'(bus.busy), 32'(exp_busy));
    check("out_data", w32(bus.out_data), w32(exp_out_data));
    for (int i = 0; i < NI; i++) check("nn_inputs", w32(bus.nn_inputs[i]), w32(exp_nn_in[i]));
`ifdef ARGMAX_EN
    check("out_class", 32'(bus.out_class), 32'(exp_class));
`endif

    // Events taking effect at the coming rising edge.
    if (!reset) begin
      if (exp_in_ready && bus.in_valid) begin
        exp_nn_in[n_loaded] = bus.in_data;
        n_loaded++;
        if (n_loaded == NI) begin
          n_loaded     = 0;
          exp_in_ready = 1'b0;
          exp_nn_rdy   = 1'b1;
          exp_busy     = 1'b1;
        end
      end else if (exp_nn_rdy && bus.nn_outputs_ready) begin
        exp_q.delete();
        pend_class = 0;
        for (int i = 0; i < NO; i++) begin
          exp_q.push_back(bus.nn_outputs[i]);
          if ($signed(bus.nn_outputs[i]) > $signed(bus.nn_outputs[pend_class])) pend_class = i;
        end
        exp_nn_rdy    = 1'b0;
        exp_out_valid = 1'b1;
        exp_out_data  = exp_q[0];
        exp_last      = (NO == 1);
        if (exp_last) exp_class = pend_class;
      end else if (exp_out_valid && bus.out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          exp_out_valid = 1'b0;
          exp_last      = 1'b0;
          exp_in_ready  = 1'b1;
          exp_busy      = 1'b0;
        end else begin
          exp_out_data = exp_q[0];
          exp_last     = (exp_q.size() == 1);
          if (exp_last) exp_class = pend_class;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_words(input logic [W-1:0] w [NI]);
    bus.in_valid = 1'b1;
    for (int i = 0; i < NI; i++) begin
      bus.in_data = w[i];
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic load_random();
    logic [W-1:0] w [NI];
    for (int i = 0; i < NI; i++) w[i] = 16'($urandom);
    load_words(w);
  endtask

  // Presents result words for one cycle in RUN, then checks the drain beat by beat.
  task automatic drain_literal(input logic [W-1:0] v [NO], input int cls);
    bus.out_ready = 1'b1;
    for (int i = 0; i < NO; i++) bus.nn_outputs[i] = v[i];
    bus.nn_outputs_ready = 1'b1;
    step();
    bus.nn_outputs_ready = 1'b0;
    for (int i = 0; i < NO; i++) bus.nn_outputs[i] = 16'($urandom);
    for (int i = 0; i < NO; i++) begin
      @(negedge clock);
      check("lit_out_valid", 32'(bus.out_valid), 32'd1);
      check("lit_out_data", w32(bus.out_data), w32(v[i]));
      check("lit_out_last", 32'(bus.out_last), 32'(i == NO - 1));
`ifdef ARGMAX_EN
      if (i == NO - 1) check("lit_out_class", 32'(bus.out_class), 32'(cls));
`else
      if (i == NO - 1) check("lit_busy_last", 32'(bus.busy), 32'(cls >= 0));
`endif
    end
    @(negedge clock);
    check("lit_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("lit_out_valid_after", 32'(bus.out_valid), 32'd0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [W-1:0] w [NI];
    logic [W-1:0] v [NO];
    logic [7:0]   ints [NO];

    bus.in_data          = '0;
    bus.in_valid         = 1'b0;
    bus.nn_outputs       = '0;
    bus.nn_outputs_ready = 1'b0;
    bus.out_ready        = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // 0.25 x NI, no network response: stays waiting.
    for (int i = 0; i < NI; i++) w[i] = 16'h0040;
    load_words(w);
    repeat (6) step();
    @(negedge clock);
    for (int i = 0; i < NI; i++) check("lit_quarter", w32(bus.nn_inputs[i]), 32'h0040);
    check("lit_wait_nn_rdy", 32'(bus.nn_inputs_ready), 32'd1);
    check("lit_wait_in_ready", 32'(bus.in_ready), 32'd0);
    check("lit_wait_out_valid", 32'(bus.out_valid), 32'd0);

    // Outputs 0..9 integral, max at 9.
    for (int i = 0; i < NO; i++) v[i] = {8'(i), 8'h00};
    drain_literal(v, 9);

    // Ties resolve to the lowest index.
    load_random();
    ints = '{8'd1, 8'd7, 8'd3, 8'd7, -8'sd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < NO; i++) v[i] = {ints[i], 8'h00};
    drain_literal(v, 1);

    // All negative, max at the last index.
    load_random();
    for (int i = 0; i < NO; i++) v[i] = {8'(i - 10), 8'h80};
    drain_literal(v, 9);

    // Reset after a partial load; only the fresh frame must land.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 16'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NI; i++) w[i] = 16'h1100 + 16'(i);
    load_words(w);
    @(negedge clock);
    for (int i = 0; i < NI; i++) check("lit_fresh", w32(bus.nn_inputs[i]), w32(w[i]));
    check("lit_fresh_nn_rdy", 32'(bus.nn_inputs_ready), 32'd1);
    for (int i = 0; i < NO; i++) v[i] = {8'(9 - i), 8'h00};
    drain_literal(v, 0);

    // Network response during LOAD is ignored.
    bus.nn_outputs_ready = 1'b1;
    step();
    bus.nn_outputs_ready = 1'b0;
    @(negedge clock);
    check("lit_ignore_valid", 32'(bus.out_valid), 32'd0);
    check("lit_ignore_busy", 32'(bus.busy), 32'd0);
    check("lit_ignore_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Randomized traffic with stalls, stray responses and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      reset                = ($urandom_range(0, 399) == 0);
      bus.in_valid         = ($urandom_range(0, 3) != 0);
      bus.in_data          = 16'($urandom);
      bus.out_ready        = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NO; i++) bus.nn_outputs[i] = 16'($urandom);
      bus.nn_outputs_ready = bus.nn_inputs_ready ? ($urandom_range(0, 3) == 0)
                                                 : ($urandom_range(0, 7) == 0);
      step();
    end
    reset                = 1'b0;
    bus.in_valid         = 1'b0;
    bus.nn_outputs_ready = 1'b0;
    bus.out_ready        = 1'b1;
    repeat (30) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_stream_sequencer.md
# nn_stream_sequencer

Streaming front/back end for `neural_network`: drives the network's parallel input handshake and consumes its parallel output handshake. It accepts input samples one per beat over a valid/ready stream and assembles them into the `inputs` array. It then raises `inputs_ready`, waits for `outputs_ready`, captures the `outputs` array and streams it back out one word per beat. It sits between a host/DMA stream and `neural_network` in the top level, replacing bench-driven stimulus.

## Interface
Parameters:
- NUM_INPUTS, 10, number of network input words (= LAYERS[0].SIZE)
- NUM_OUTPUTS, 10, number of network output words (= LAYERS[NUM_LAYERS-1].SIZE)

Ports (W = INTEGER_WIDTH + FRACTION_WIDTH; words are `signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]`):
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- in_data  in  W  input sample
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts in_data
- nn_inputs  out  W x NUM_INPUTS  to network `inputs`
- nn_inputs_ready  out  1  to network `inputs_ready`
- nn_outputs  in  W x NUM_OUTPUTS  from network `outputs`
- nn_outputs_ready  in  1  from network `outputs_ready`
- out_data  out  W  result word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_last  out  1  marks word NUM_OUTPUTS-1
- out_class  out  $clog2(NUM_OUTPUTS)  argmax index (ARGMAX_EN only)
- busy  out  1  high in RUN or DRAIN

## Operation
- States: LOAD, RUN, DRAIN. Reset state LOAD.
- LOAD: in_ready=1. Each beat (in_valid && in_ready) writes nn_inputs[in_count] and increments in_count. The beat with in_count==NUM_INPUTS-1 moves to RUN and clears in_count.
- RUN: in_ready=0, nn_inputs_ready=1 (level), nn_inputs held stable. nn_outputs_ready sampled 1 captures nn_outputs into an internal buffer, clears nn_inputs_ready and moves to DRAIN.
- DRAIN: out_valid=1, out_data=buffer[out_count], out_last=(out_count==NUM_OUTPUTS-1). Each beat (out_valid && out_ready) increments out_count. The last beat clears out_count and returns to LOAD.
- nn_outputs_ready is ignored outside RUN. It is honoured in the first RUN cycle.
- out_data is held stable while out_valid && !out_ready.
- Reset mid-operation discards any partial load, capture or drain. Reset also cancels nn_inputs_ready immediately.
- No arithmetic on data path. Words are passed bit-exact.

## Timing
- Reset values: in_ready=1, nn_inputs_ready=0, nn_inputs all 0, out_valid=0, out_data=0, out_last=0, out_class=0, busy=0.
- Last input beat at cycle t: nn_inputs_ready=1 and in_ready=0 from t+1.
- nn_outputs_ready high at cycle t in RUN: nn_inputs_ready=0 and out_valid=1 from t+1, with out_data=word 0.
- Last output beat at cycle t: in_ready=1 from t+1.
- Minimum inference period is NUM_INPUTS + 1 + NUM_OUTPUTS cycles, with in_valid, out_ready and nn_outputs_ready all continuously high.
- Registered outputs only. No combinational path from in_valid or out_ready to any output.

## Configuration
- ARGMAX_EN defined: out_class port exists. A running max/index over the captured words is computed during DRAIN by signed compare. The strictly-greater rule means ties resolve to the lowest index. out_class is valid whenever out_valid && out_last, and covers all NUM_OUTPUTS words. out_class resets to 0 and holds until the next DRAIN completes.
- ARGMAX_EN undefined: out_class port and tracker logic are absent. Behaviour is otherwise identical.

## Structure
- Shared include/package holds INTEGER_WIDTH and FRACTION_WIDTH. It also holds the fixed-point word typedef (packed struct with `integral` and `fraction` fields) and the state enum (LOAD/RUN/DRAIN).
- One sub-module: `argmax_tracker`, instantiated only under ARGMAX_EN. It takes the word, its index, a beat strobe and a start-clear, and outputs the index.

## Test plan
- Reset, then stream inputs 0.25 x 10 with nn_outputs_ready tied to 0 -> nn_inputs all 0.25, nn_inputs_ready=1, in_ready=0, out_valid=0 indefinitely.
- Same, then pulse nn_outputs_ready for 1 cycle with outputs 0..9 (integral) and out_ready=1 -> 10 beats on consecutive cycles starting the next cycle, values 0..9, out_last only on 9, in_ready=1 after.
- Random out_ready stalls (50%) during DRAIN -> out_data stable while stalled, every word delivered exactly once in order.
- Assert reset after 5 input beats, then send 10 fresh beats -> only the fresh beats appear on nn_inputs, with no early nn_inputs_ready.
- Pulse nn_outputs_ready during LOAD -> ignored, no out_valid.
- ARGMAX_EN with outputs {1,7,3,7,-2,...} -> out_class=1 on the out_last beat. With all outputs negative and max at index 9 -> out_class=9.
